db_sync_gen: RTL and testbench

Timing source for the DB bus. It produces the HS, VS, DF_UART and DF_VGA signals that the display/UART datapath consumes, from free-running horizontal and vertical counters driven by a divided pixel tick. It sits at the front of the DB path as the driver-side counterpart of the DB monitor/consumer. All outputs are registered and directly drive the DB bus.

---
 rtl/db_sync_gen.sv | 108 ++++++++++
 tb/tb_db_sync_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/db_sync_gen.sv
// DB bus timing source: HS/VS/DF_VGA/DF_UART from free-running h/v counters on a divided pixel tick.
// All outputs registered from next-counter values, so flags stay aligned with h_cnt/v_cnt; en=0 freezes everything.
module db_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             HS,
  output logic             VS,
  output logic             DF_VGA,
  output logic             DF_UART,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Phase bounds carry one extra bit so a sync end equal to 2^CNT_W cannot alias to zero.
  localparam logic [CNT_W:0] H_ACT_E  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SYNC_S = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SYNC_E = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_E  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SYNC_S = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SYNC_E = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_hs;
  logic             r_vs;
  logic             r_vga;
  logic             r_uart;

  logic             w_tick;
  logic             w_h_wrap;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic [CNT_W:0]   w_h_ext;
  logic [CNT_W:0]   w_v_ext;
  logic             w_hs_nxt;
  logic             w_vs_nxt;
  logic             w_vga_nxt;
  logic             w_uart_nxt;

  assign w_tick   = en && (r_div == DIV_LAST);
  assign w_h_wrap = (r_h == H_LAST);
  assign w_h_nxt  = w_h_wrap ? '0 : r_h + 1'b1;
  assign w_v_nxt  = !w_h_wrap ? r_v : ((r_v == V_LAST) ? '0 : r_v + 1'b1);
  assign w_h_ext  = {1'b0, w_h_nxt};
  assign w_v_ext  = {1'b0, w_v_nxt};

  assign w_hs_nxt   = ((w_h_ext >= H_SYNC_S) && (w_h_ext < H_SYNC_E)) ? HS_POL : ~HS_POL;
  assign w_vs_nxt   = ((w_v_ext >= V_SYNC_S) && (w_v_ext < V_SYNC_E)) ? VS_POL : ~VS_POL;
  assign w_vga_nxt  = (w_h_ext < H_ACT_E) && (w_v_ext < V_ACT_E);
  // Only the line wrap into the first blanking line strobes; the frame wrap lands on v=0.
  assign w_uart_nxt = w_h_wrap && (w_v_ext == V_ACT_E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_h    <= '0;
      r_v    <= '0;
      r_hs   <= ~HS_POL;
      r_vs   <= ~VS_POL;
      r_vga  <= 1'b0;
      r_uart <= 1'b0;
    end else begin
      r_uart <= 1'b0;
      if (en) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
      end
      if (w_tick) begin
        r_h    <= w_h_nxt;
        r_v    <= w_v_nxt;
        r_hs   <= w_hs_nxt;
        r_vs   <= w_vs_nxt;
        r_vga  <= w_vga_nxt;
        r_uart <= w_uart_nxt;
      end
    end
  end

  assign HS      = r_hs;
  assign VS      = r_vs;
  assign DF_VGA  = r_vga;
  assign DF_UART = r_uart;
  assign h_cnt   = r_h;
  assign v_cnt   = r_v;

endmodule

// File: tb/tb_db_sync_gen.sv
// Directed bench for db_sync_gen on an 8x6 raster: one instance at CLK_DIV=1, one at CLK_DIV=3.
module tb_db_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, en0, hs0, vs0, vga0, uart0;
  logic [3:0] h0, v0;
  logic       rst1_n, en1, hs1, vs1, vga1, uart1;
  logic [3:0] h1, v1;

  int n_vec = 0;
  int n_err = 0;

  db_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .CNT_W(4)
  ) u_div1 (
    .clk(clk), .rst_n(rst0_n), .en(en0),
    .HS(hs0), .VS(vs0), .DF_VGA(vga0), .DF_UART(uart0),
    .h_cnt(h0), .v_cnt(v0)
  );

  db_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(3), .CNT_W(4)
  ) u_div3 (
    .clk(clk), .rst_n(rst1_n), .en(en1),
    .HS(hs1), .VS(vs1), .DF_VGA(vga1), .DF_UART(uart1),
    .h_cnt(h1), .v_cnt(v1)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packed {h[3:0], v[3:0], HS, VS, DF_VGA, DF_UART} after n pixel ticks since reset.
  function automatic logic [11:0] exp_vec(input int n, input bit strobe);
    int h, v;
    logic hs, vs, vga, uart;
    h    = n % 8;
    v    = (n / 8) % 6;
    hs   = !(h == 5 || h == 6);
    vs   = !(v == 4);
    vga  = (n > 0) && (h < 4) && (v < 3);
    uart = strobe && (h == 0) && (v == 3);
    return {h[3:0], v[3:0], hs, vs, vga, uart};
  endfunction

  function automatic logic [11:0] reset_vec();
    return 12'b0000_0000_1_1_0_0;
  endfunction

  initial begin
    int e, hold, vga_cnt, uart_cnt;
    bit tk, d1, d2;
    logic [11:0] got0, got1;

    rst0_n = 1'b1; rst1_n = 1'b1; en0 = 1'b0; en1 = 1'b0;
    #2;
    rst0_n = 1'b0; rst1_n = 1'b0;
    @(negedge clk);
    check_vec("rst_div1", 32'({h0, v0, hs0, vs0, vga0, uart0}), 32'(reset_vec()));
    check_vec("rst_div3", 32'({h1, v1, hs1, vs1, vga1, uart1}), 32'(reset_vec()));

    // CLK_DIV=1: every enabled edge is a tick.
    rst0_n = 1'b1; en0 = 1'b1;
    e = 0; vga_cnt = 0; uart_cnt = 0;
    repeat (101) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      got0 = {h0, v0, hs0, vs0, vga0, uart0};
      check_vec($sformatf("div1_n%0d", e), 32'(got0), 32'(exp_vec(e, 1'b1)));
      if (e <= 48) begin
        vga_cnt  += int'(vga0);
        uart_cnt += int'(uart0);
      end
    end
    check_vec("vga_per_frame", 32'(vga_cnt), 32'd12);
    check_vec("uart_per_frame", 32'(uart_cnt), 32'd1);

    // Now at h=5 (HS asserted): async reset between edges.
    #2;
    rst0_n = 1'b0;
    #1;
    check_vec("async_rst", 32'({h0, v0, hs0, vs0, vga0, uart0}), 32'(reset_vec()));
    @(negedge clk);
    rst0_n = 1'b1;
    e = 0;
    repeat (10) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      check_vec($sformatf("post_rst_n%0d", e), 32'({h0, v0, hs0, vs0, vga0, uart0}),
                32'(exp_vec(e, 1'b1)));
    end
    en0 = 1'b0;

    // CLK_DIV=3 with two enable drops: mid-line at div=1, and just before the strobe tick.
    rst1_n = 1'b1;
    e = 0; hold = 0; d1 = 0; d2 = 0; uart_cnt = 0;
    repeat (320) begin
      if (!d1 && e == 31) begin hold = 10; d1 = 1; end
      if (!d2 && e == 71) begin hold = 5;  d2 = 1; end
      en1 = (hold == 0);
      if (hold > 0) hold--;
      @(posedge clk);
      tk = en1 && (e % 3 == 2);
      if (en1) e++;
      @(negedge clk);
      got1 = {h1, v1, hs1, vs1, vga1, uart1};
      check_vec($sformatf("div3_e%0d_en%0d", e, en1), 32'(got1), 32'(exp_vec(e / 3, tk)));
      uart_cnt += int'(uart1);
    end
    check_vec("uart_two_frames", 32'(uart_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
